// File: rtl/dct_transpose_if.sv
// Stream bundle for the DCT transpose controller: raster-order input, column-order output.
// The controller takes the slave modport and the row/column pass logic takes the master modport.
interface dct_transpose_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sob;
  logic                  out_eob;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sob, out_eob
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_eob
  );
endinterface

// File: rtl/dct_transpose_ctrl.sv
// Ping-pong 8x8 transpose between the row-pass and column-pass DCT, one sample/clk sustained.
// Optional DCT_TRANSPOSE_SOB_CHECK_EN adds in_sob / sob_err block-alignment checking and resync.
module dct_transpose_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int BLK        = 8
) (
  input  logic             clk,
  input  logic             rst,
  dct_transpose_if.slave   bus,
  output logic [1:0]       banks_full
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
  ,
  input  logic             in_sob,
  output logic             sob_err
`endif
);

  localparam int NS = BLK * BLK;
  localparam int IW = $clog2(NS);

  if (BLK != 8) begin : g_blk_check
    $error("dct_transpose_ctrl: only BLK=8 is supported");
  end

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_t;

  bank_st_t              st_q [2];
  bank_st_t              st_d [2];
  logic                  wr_bank, rd_bank, out_bank;
  logic [IW-1:0]         wr_idx, rd_idx, wr_pos, rd_pos;
  logic [DATA_WIDTH-1:0] mem [2*NS];
  logic [1:0]            writable;
  logic                  wr_fire, wr_last, rd_avail, rd_load, rd_last, out_fire;

`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
  // A start-of-block marker mid-block abandons the partial block and restarts at index 0.
  assign wr_pos = in_sob ? '0 : wr_idx;
`else
  assign wr_pos = wr_idx;
`endif

  assign rd_pos   = {rd_idx[2:0], rd_idx[5:3]};
  assign wr_fire  = bus.in_valid && bus.in_ready;
  assign wr_last  = wr_fire && (wr_pos == IW'(NS - 1));
  assign rd_last  = (rd_idx == IW'(NS - 1));
  assign out_fire = bus.out_valid && bus.out_ready;
  assign rd_load  = (!bus.out_valid || bus.out_ready) && rd_avail;
  assign bus.in_ready = !rst && writable[wr_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (out_fire && bus.out_eob && (out_bank == 1'(b)) && (st_q[b] == DRAINING))
        st_d[b] = EMPTY;
      if (rd_load && (rd_bank == 1'(b)) && (st_q[b] == FULL))
        st_d[b] = DRAINING;
      // A fully-read bank may be refilled while its last sample still sits in the output register.
      if (wr_fire && (wr_bank == 1'(b)))
        st_d[b] = wr_last ? FULL : FILLING;
    end
  end

  always_comb begin
    writable   = 2'b00;
    banks_full = 2'b00;
    for (int b = 0; b < 2; b++) begin
      writable[b]   = (st_q[b] == EMPTY) || (st_q[b] == FILLING) ||
                      ((st_q[b] == DRAINING) && (rd_bank != 1'(b)));
      banks_full[b] = (st_q[b] == FULL) || (st_q[b] == DRAINING);
    end
    rd_avail = (st_q[rd_bank] == FULL) || (st_q[rd_bank] == DRAINING);
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[{wr_bank, wr_pos}] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      out_bank      <= 1'b0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sob   <= 1'b0;
      bus.out_eob   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_idx <= wr_last ? '0 : wr_pos + 1'b1;
        if (wr_last)
          wr_bank <= ~wr_bank;
      end
      if (rd_load) begin
        bus.out_data  <= mem[{rd_bank, rd_pos}];
        bus.out_valid <= 1'b1;
        bus.out_sob   <= (rd_idx == '0);
        bus.out_eob   <= rd_last;
        out_bank      <= rd_bank;
        rd_idx        <= rd_idx + 1'b1;
        if (rd_last)
          rd_bank <= ~rd_bank;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
        bus.out_sob   <= 1'b0;
        bus.out_eob   <= 1'b0;
      end
    end
  end

`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      sob_err <= 1'b0;
    else if (wr_fire && (in_sob != (wr_idx == '0)))
      sob_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Scoreboard bench for dct_transpose_ctrl: expected transposed blocks are queued as input
// blocks complete and compared on each output handshake.
module tb_dct_transpose_ctrl;

  typedef struct packed { logic [9:0] d; logic sob; } in_t;
  typedef struct packed { logic [9:0] d; logic sob; logic eob; } ex_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] banks_full;
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
  logic       in_sob;
  logic       sob_err;
`endif

  dct_transpose_if #(.DATA_WIDTH(10)) bus ();

  dct_transpose_ctrl #(.DATA_WIDTH(10), .BLK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .banks_full (banks_full)
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
    ,
    .in_sob     (in_sob),
    .sob_err    (sob_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  in_t        src [$];
  ex_t        exp_q [$];
  logic [9:0] blk [64];
  int         wcnt;
  int         cyc = 0;
  int         ordy_mode;
  int         n_acc, n_out, last_acc, first_out, in_block, out_gap, chk_ready_at;
  logic       seen_out;
  logic       hold_vld, hold_sob, hold_eob;
  logic [9:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; n_out = 0; last_acc = -1; first_out = -1;
    in_block = 0; out_gap = 0; seen_out = 1'b0; chk_ready_at = -1;
  endtask

  task automatic model_accept(input in_t s);
    ex_t e;
    int  k;
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
    if (s.sob) wcnt = 0;
`endif
    blk[wcnt] = s.d;
    wcnt++;
    if (wcnt == 64) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++) begin
          k     = c * 8 + r;
          e.d   = blk[r * 8 + c];
          e.sob = (k == 0);
          e.eob = (k == 63);
          exp_q.push_back(e);
        end
      wcnt = 0;
    end
  endtask

  // One clock: drive at the falling edge, evaluate both handshakes, advance to the next falling edge.
  task automatic step();
    ex_t e;
    bus.in_valid = (src.size() > 0);
    if (src.size() > 0) begin
      bus.in_data = src[0].d;
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
      in_sob = src[0].sob;
`endif
    end
    case (ordy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = cyc[0];
    endcase
    #1;
    if (n_out == chk_ready_at) begin
      chk("in_ready_back", bus.in_ready, 1);
      chk_ready_at = -1;
    end
    if (hold_vld) begin
      chk("stall_vld", bus.out_valid, 1);
      chk("stall_data", bus.out_data, hold_d);
      chk("stall_sob", bus.out_sob, hold_sob);
      chk("stall_eob", bus.out_eob, hold_eob);
    end
    hold_vld = bus.out_valid && !bus.out_ready;
    hold_d   = bus.out_data;
    hold_sob = bus.out_sob;
    hold_eob = bus.out_eob;
    if (bus.out_valid && !seen_out) begin
      seen_out  = 1'b1;
      first_out = cyc;
    end
    if (seen_out && !bus.out_valid && exp_q.size() > 0) out_gap++;
    if (bus.in_valid && !bus.in_ready) in_block++;
    if (bus.in_valid && bus.in_ready) begin
      model_accept(src.pop_front());
      n_acc++;
      last_acc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_sob", bus.out_sob, e.sob);
        chk("out_eob", bus.out_eob, e.eob);
      end
      n_out++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", src.size() + exp_q.size(), 0);
  endtask

  task automatic push_blk(input int base, input int n);
    in_t s;
    for (int i = 0; i < n; i++) begin
      s.d   = 10'(base + i);
      s.sob = ((i % 64) == 0);
      src.push_back(s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    src.delete();
    exp_q.delete();
    wcnt     = 0;
    hold_vld = 1'b0;
    #1;
    chk("rst_ready_after", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sob", bus.out_sob, 0);
    chk("rst_out_eob", bus.out_eob, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_banks_full", banks_full, 0);
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
    chk("rst_sob_err", sob_err, 0);
`endif
    clear_stats();
  endtask

  initial begin
    in_t s;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
    in_sob = 1'b0;
`endif
    wcnt = 0;
    hold_vld = 1'b0;
    clear_stats();
    @(negedge clk);

    // Single block 0..63 with the sink always ready.
    do_reset();
    ordy_mode = 1;
    push_blk(0, 64);
    drain(300);
    chk("blk1_outputs", n_out, 64);
    chk("blk1_latency", first_out - last_acc, 2);

    // Three blocks back to back: no input stall, no output bubble.
    do_reset();
    push_blk(0, 64);
    push_blk(100, 64);
    push_blk(200, 64);
    drain(600);
    chk("b2b_outputs", n_out, 192);
    chk("b2b_in_stalls", in_block, 0);
    chk("b2b_out_gaps", out_gap, 0);

    // Sink blocked: both banks fill, then drain in order.
    do_reset();
    ordy_mode = 0;
    push_blk(0, 200);
    run(200);
    chk("full_accepted", n_acc, 128);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_banks", banks_full, 2'b11);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_out_data", bus.out_data, 0);
    ordy_mode    = 1;
    chk_ready_at = 64;
    drain(1000);
    chk("full_outputs", n_out, 192);
    chk("full_ready_seen", chk_ready_at, -1);

    // Alternating sink readiness with random samples.
    do_reset();
    ordy_mode = 2;
    for (int i = 0; i < 128; i++) begin
      s.d   = 10'($urandom_range(0, 1023));
      s.sob = ((i % 64) == 0);
      src.push_back(s);
    end
    drain(1000);
    chk("toggle_outputs", n_out, 128);

    // Reset in the middle of a block discards it.
    do_reset();
    ordy_mode = 1;
    push_blk(500, 30);
    run(30);
    do_reset();
    push_blk(0, 64);
    drain(300);
    chk("post_rst_outputs", n_out, 64);

`ifdef DCT_TRANSPOSE_SOB_CHECK_EN
    // Early start-of-block on the 10th sample resyncs the block.
    do_reset();
    push_blk(700, 9);
    push_blk(600, 64);
    drain(400);
    chk("sob_err_set", sob_err, 1);
    chk("sob_outputs", n_out, 64);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
